// File: rtl/whack_round_engine.sv
// Whack-a-mole round engine: LFSR hole pick, show/arm/gap timing, hit edge scoring, miss count; outputs register one cycle after the deciding edge.
// Build option WHACK_PENALTY_EN: an armed wrong-hole edge costs one point (saturating at zero).
module whack_round_engine #(
    parameter int          MOLES     = 4,
    parameter int          SCORE_W   = 8,
    parameter int          SHOW_CYC  = 100_000_000,
    parameter int          ARM_CYC   = 50_000_000,
    parameter int          GAP_CYC   = 25_000_000,
    parameter int          MAX_MISS  = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [MOLES-1:0]   hit,
    output logic [MOLES-1:0]   mole_onehot,
    output logic [SCORE_W-1:0] score_out,
    output logic [3:0]         miss_count,
    output logic               wren,
    output logic               round_done,
    output logic               game_over,
    output logic               busy
);
    localparam int IDX_W   = (MOLES > 1) ? $clog2(MOLES) : 1;
    localparam int CNT_MAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] ARM_LIM   = CNT_W'(ARM_CYC);
    localparam logic [3:0]       MISS_LIM  = 4'(MAX_MISS);

    typedef enum logic [1:0] {IDLE, SHOW, GAP, OVER} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [15:0]        lfsr;
    logic [MOLES-1:0]   hit_prev, hit_edge, mole_nxt;
    logic [IDX_W-1:0]   prev_idx, prev_nxt, pick_idx;
    logic [SCORE_W-1:0] score_nxt;
    logic [3:0]         miss_nxt;
    logic               wren_nxt, done_nxt, armed, hit_good;
`ifdef WHACK_PENALTY_EN
    logic               hit_bad;
`endif

    assign hit_edge  = hit & ~hit_prev;
    assign armed     = (cnt >= ARM_LIM);
    assign hit_good  = armed && |(hit_edge & mole_onehot);
`ifdef WHACK_PENALTY_EN
    assign hit_bad   = armed && |(hit_edge & ~mole_onehot);
`endif
    assign game_over = (state == OVER);
    assign busy      = (state == SHOW) || (state == GAP);

    // A repeated pick moves to the next hole; the index wraps because MOLES is a power of two.
    assign pick_idx = (lfsr[IDX_W-1:0] == prev_idx) ? lfsr[IDX_W-1:0] + IDX_W'(1)
                                                    : lfsr[IDX_W-1:0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        score_nxt = score_out;
        miss_nxt  = miss_count;
        mole_nxt  = mole_onehot;
        prev_nxt  = prev_idx;
        wren_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    score_nxt = '0;
                    miss_nxt  = '0;
                    mole_nxt  = MOLES'(1) << pick_idx;
                    prev_nxt  = pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (hit_good) begin
                    if (score_out != '1) begin
                        score_nxt = score_out + SCORE_W'(1);
                        wren_nxt  = 1'b1;
                    end
                    done_nxt  = 1'b1;
                    mole_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end else begin
`ifdef WHACK_PENALTY_EN
                    if (hit_bad && score_out != '0) begin
                        score_nxt = score_out - SCORE_W'(1);
                        wren_nxt  = 1'b1;
                    end
`endif
                    if (cnt == SHOW_LAST) begin
                        miss_nxt  = miss_count + 4'd1;
                        done_nxt  = 1'b1;
                        mole_nxt  = '0;
                        cnt_nxt   = '0;
                        state_nxt = (miss_nxt == MISS_LIM) ? OVER : GAP;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    mole_nxt  = MOLES'(1) << pick_idx;
                    prev_nxt  = pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = SHOW;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lfsr        <= LFSR_SEED;
            hit_prev    <= '0;
            prev_idx    <= '0;
            mole_onehot <= '0;
            score_out   <= '0;
            miss_count  <= '0;
            wren        <= 1'b0;
            round_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
            lfsr        <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
            hit_prev    <= hit;
            prev_idx    <= prev_nxt;
            mole_onehot <= mole_nxt;
            score_out   <= score_nxt;
            miss_count  <= miss_nxt;
            wren        <= wren_nxt;
            round_done  <= done_nxt;
        end
    end
endmodule

// File: tb/tb_whack_round_engine.sv
// Bench for whack_round_engine: directed game scenarios then random presses, all checked each cycle against a behavioural game model.
module tb_whack_round_engine;
    localparam int          MOLES    = 4;
    localparam int          SCORE_W  = 2;
    localparam int          SHOW_CYC = 20;
    localparam int          ARM_CYC  = 10;
    localparam int          GAP_CYC  = 5;
    localparam int          MAX_MISS = 3;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam int          SMAX     = (1 << SCORE_W) - 1;
    localparam int PH_IDLE = 0, PH_SHOW = 1, PH_GAP = 2, PH_OVER = 3;

    logic               clk = 1'b0;
    logic               Reset = 1'b1;
    logic               start = 1'b0;
    logic [MOLES-1:0]   hit = '0;
    logic [MOLES-1:0]   mole_onehot;
    logic [SCORE_W-1:0] score_out;
    logic [3:0]         miss_count;
    logic               wren, round_done, game_over, busy;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural game model
    int          m_phase = PH_IDLE;
    int          m_elapsed = 0;
    int          m_score = 0;
    int          m_miss = 0;
    int          m_hole = 0;
    int          m_prev = 0;
    logic [15:0] m_lfsr = SEED;
    logic [3:0]  m_hit_prev = '0;
    bit          m_wren = 0;
    bit          m_done = 0;

    always #5 clk = ~clk;

    whack_round_engine #(
        .MOLES(MOLES), .SCORE_W(SCORE_W), .SHOW_CYC(SHOW_CYC), .ARM_CYC(ARM_CYC),
        .GAP_CYC(GAP_CYC), .MAX_MISS(MAX_MISS), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .Reset(Reset), .start(start), .hit(hit),
        .mole_onehot(mole_onehot), .score_out(score_out), .miss_count(miss_count),
        .wren(wren), .round_done(round_done), .game_over(game_over), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        // feedback taps from polynomial exponents 16,14,13,11
        logic [15:0] taps;
        taps = (16'h1 << (16 - 1)) | (16'h1 << (14 - 1)) | (16'h1 << (13 - 1)) | (16'h1 << (11 - 1));
        return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [3:0] em;
        em = (m_phase == PH_SHOW) ? 4'(1 << m_hole) : 4'd0;
        return {18'd0, em, 2'(m_score), 4'(m_miss), m_wren, m_done,
                m_phase == PH_OVER, m_phase == PH_SHOW || m_phase == PH_GAP};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {18'd0, mole_onehot, score_out, miss_count, wren, round_done, game_over, busy};
    endfunction

    task automatic model_pick();
        int idx;
        idx = int'(m_lfsr) % MOLES;
        if (idx == m_prev) idx = (idx + 1) % MOLES;
        m_hole = idx;
        m_prev = idx;
    endtask

    task automatic model_step();
        logic [3:0] edges;
        bit good, bad;
        int nxt;
        edges  = hit & ~m_hit_prev;
        m_wren = 0;
        m_done = 0;
        if (Reset) begin
            m_phase = PH_IDLE; m_elapsed = 0; m_score = 0; m_miss = 0;
            m_prev = 0; m_lfsr = SEED; m_hit_prev = '0;
            return;
        end
        if (m_phase == PH_IDLE || m_phase == PH_OVER) begin
            if (start) begin
                m_score = 0; m_miss = 0; model_pick();
                m_phase = PH_SHOW; m_elapsed = 0;
            end
        end else if (m_phase == PH_SHOW) begin
            good = (m_elapsed >= ARM_CYC) && edges[m_hole];
            bad  = (m_elapsed >= ARM_CYC) && ((edges & ~4'(1 << m_hole)) != 0);
            if (good) begin
                nxt = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
                m_wren = (nxt != m_score);
                m_score = nxt;
                m_done = 1; m_phase = PH_GAP; m_elapsed = 0;
            end else begin
`ifdef WHACK_PENALTY_EN
                if (bad && m_score > 0) begin
                    m_score = m_score - 1; m_wren = 1;
                end
`else
                if (bad) m_wren = 0;
`endif
                if (m_elapsed == SHOW_CYC - 1) begin
                    m_miss++; m_done = 1; m_elapsed = 0;
                    m_phase = (m_miss == MAX_MISS) ? PH_OVER : PH_GAP;
                end else m_elapsed++;
            end
        end else begin
            if (m_elapsed == GAP_CYC - 1) begin
                model_pick(); m_phase = PH_SHOW; m_elapsed = 0;
            end else m_elapsed++;
        end
        m_lfsr = lfsr_next(m_lfsr);
        m_hit_prev = hit;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_eq("cycle", dut_vec(), exp_vec());
    endtask

    task automatic wait_show(input int k);
        int n;
        n = 0;
        hit = '0;
        while (!(m_phase == PH_SHOW && m_elapsed == k) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check_eq("wait_show_timeout", 32'd0, 32'd1);
    endtask

    logic [3:0] first_mole;
    int         pick;

    initial begin
        tick(); tick();
        check_eq("reset_outputs", dut_vec(), 32'd0);
        Reset = 1'b0;
        tick();

        // armed hit at counter 12
        start = 1'b1; tick(); start = 1'b0;
        check_eq("start_busy", 32'(busy), 32'd1);
        wait_show(12);
        first_mole = 4'(1 << m_hole);
        hit = first_mole; tick();
        check_eq("armed_score", 32'(score_out), 32'd1);
        check_eq("armed_wren", 32'(wren), 32'd1);
        check_eq("armed_done", 32'(round_done), 32'd1);
        check_eq("armed_dark", 32'(mole_onehot), 32'd0);
        hit = '0; tick();
        check_eq("wren_once", 32'(wren), 32'd0);
        repeat (3) tick();
        check_eq("gap_dark5", 32'(mole_onehot), 32'd0);
        tick();
        check_eq("new_hole_differs", 32'(mole_onehot != 0 && mole_onehot != first_mole), 32'd1);

        // early hit ignored, then timeout
        wait_show(5);
        hit = 4'(1 << m_hole); tick(); hit = '0;
        check_eq("early_score", 32'(score_out), 32'd1);
        wait_show(19); tick();
        check_eq("timeout_miss", 32'(miss_count), 32'd1);
        check_eq("timeout_done", 32'(round_done), 32'd1);

        // hit on the timeout cycle wins
        wait_show(19);
        hit = 4'(1 << m_hole); tick(); hit = '0;
        check_eq("lastcyc_score", 32'(score_out), 32'd2);
        check_eq("lastcyc_miss", 32'(miss_count), 32'd1);

        // wrong hole while armed
        wait_show(11);
        hit = 4'(1 << ((m_hole + 1) % MOLES)); tick(); hit = '0;
`ifdef WHACK_PENALTY_EN
        check_eq("penalty_score", 32'(score_out), 32'd1);
        check_eq("penalty_wren", 32'(wren), 32'd1);
`else
        check_eq("penalty_score", 32'(score_out), 32'd2);
        check_eq("penalty_wren", 32'(wren), 32'd0);
`endif
        check_eq("penalty_mole_up", 32'(mole_onehot != 0), 32'd1);

        // climb to max score, then saturate
        for (int r = 0; r < 5 && m_score < SMAX; r++) begin
            wait_show(12);
            hit = 4'(1 << m_hole); tick(); hit = '0;
        end
        wait_show(12);
        hit = 4'(1 << m_hole); tick(); hit = '0;
        check_eq("sat_score", 32'(score_out), 32'd3);
        check_eq("sat_wren", 32'(wren), 32'd0);
        check_eq("sat_done", 32'(round_done), 32'd1);

        // remaining timeouts end the game
        for (int r = 0; r < 4 && m_phase != PH_OVER; r++) begin
            wait_show(19); tick();
        end
        check_eq("over_flag", 32'(game_over), 32'd1);
        check_eq("over_busy", 32'(busy), 32'd0);
        check_eq("over_miss", 32'(miss_count), 32'd3);
        for (int i = 0; i < 10; i++) begin
            hit = 4'($urandom_range(0, 15)); tick();
        end
        hit = '0;
        check_eq("over_hold_score", 32'(score_out), 32'd3);
        check_eq("over_hold_miss", 32'(miss_count), 32'd3);
        start = 1'b1; tick(); start = 1'b0;
        check_eq("restart_score", 32'(score_out), 32'd0);
        check_eq("restart_miss", 32'(miss_count), 32'd0);
        check_eq("restart_busy", 32'(busy), 32'd1);

        // wrong hole at score 0
        wait_show(11);
        hit = 4'(1 << ((m_hole + 2) % MOLES)); tick(); hit = '0;
        check_eq("zero_pen_wren", 32'(wren), 32'd0);
        check_eq("zero_pen_score", 32'(score_out), 32'd0);

        // reset in the middle of a show
        wait_show(7);
        Reset = 1'b1; tick(); Reset = 1'b0;
        check_eq("rst_mid_outputs", dut_vec(), 32'd0);
        tick();
        check_eq("idle_hold", dut_vec(), 32'd0);

        // random play
        for (int c = 0; c < 3000; c++) begin
            Reset = ($urandom_range(0, 399) == 0);
            if (m_phase == PH_IDLE || m_phase == PH_OVER) start = ($urandom_range(0, 3) == 0);
            else start = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 9))
                6: hit = '0;
                7: if (m_phase == PH_SHOW) hit = 4'(1 << m_hole);
                8: hit = 4'($urandom_range(0, 15));
                9: begin
                    pick = $urandom_range(0, 3);
                    hit[pick] = ~hit[pick];
                end
                default: ;
            endcase
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
